// File: rtl/parity_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parity_tx_pkg
//  Description : Shared definitions for the parity transmit framer: FSM state
//                encoding, frame length and parity-mode constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package parity_tx_pkg;

  // FSM state encoding (3-bit)
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_START  = START,
    ST_DATA   = DATA,
    ST_PARITY = PARITY,
    ST_STOP   = STOP
  } state_t;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  // parity_mode encoding
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage : parity_tx_pkg
`default_nettype wire

// File: rtl/bit_period_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bit_period_counter
//  Description : Counts 0..CLKS_PER_BIT-1 and flags the last cycle of each
//                serial bit period.
//  Ports       : clk   - system clock, rising edge
//                rst_n - asynchronous active-low reset
//                clear - hold the count at zero (used while the line is idle)
//                tick  - high on the last cycle of each bit period
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_period_counter #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int            CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear || tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  // With CLKS_PER_BIT=1 the count never leaves zero, so tick is constant high.
  assign tick = (r_count == C_LAST);

endmodule : bit_period_counter
`default_nettype wire

// File: rtl/parity_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : parity_tx_framer
//  Description : Serialises a checked byte as a UART-style frame
//                (start, 8 data bits LSB-first, parity, stop) using the
//                upstream even/odd parity flags. Loads carrying inconsistent
//                flags are rejected with a one-cycle err pulse.
//  Ports       : clk         - system clock, rising edge
//                rst_n       - asynchronous active-low reset
//                data_in     - byte to transmit, sampled on accepted load
//                even_parity - upstream flag: data_in has an even ones count
//                odd_parity  - upstream flag: data_in has an odd ones count
//                parity_mode - 0 = even-parity frame, 1 = odd-parity frame
//                load        - request to send (pulse or level)
//                tx          - serial line, idle high
//                busy        - frame in progress
//                done        - one-cycle pulse at frame completion
//                err         - one-cycle pulse on a rejected load
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_tx_framer
  import parity_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 even_parity,
  input  logic                 odd_parity,
  input  logic                 parity_mode,
  input  logic                 load,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [2:0] C_LAST_IDX = 3'(DATA_BITS - 1);

  state_t               r_state,    w_state_nxt;
  logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
  logic [2:0]           r_idx,      w_idx_nxt;
  logic                 r_mode,     w_mode_nxt;
  logic                 r_odd_flag, w_odd_flag_nxt;
  logic                 w_tx_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;
  logic                 w_tick;
  logic                 w_par_bit;

  bit_period_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_period_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (r_state == ST_IDLE),
    .tick  (w_tick)
  );

  // Once a load is accepted the flags are known complementary, so the
  // captured odd flag alone determines the parity bit for either mode.
  assign w_par_bit = (r_mode == PAR_EVEN) ? r_odd_flag : ~r_odd_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_idx      <= '0;
      r_mode     <= PAR_EVEN;
      r_odd_flag <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_idx      <= w_idx_nxt;
      r_mode     <= w_mode_nxt;
      r_odd_flag <= w_odd_flag_nxt;
      tx         <= w_tx_nxt;
      busy       <= w_busy_nxt;
      done       <= w_done_nxt;
      err        <= w_err_nxt;
    end
  end

  // Next-state and next-output logic. tx/busy are registered, so each
  // branch produces the value the line must carry after the coming edge.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_idx_nxt      = r_idx;
    w_mode_nxt     = r_mode;
    w_odd_flag_nxt = r_odd_flag;
    w_tx_nxt       = 1'b1;
    w_busy_nxt     = 1'b1;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_busy_nxt = 1'b0;
        if (load) begin
          if (even_parity ^ odd_parity) begin
            w_state_nxt    = ST_START;
            w_shift_nxt    = data_in;
            w_mode_nxt     = parity_mode;
            w_odd_flag_nxt = odd_parity;
            w_idx_nxt      = '0;
            w_tx_nxt       = 1'b0;
            w_busy_nxt     = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      ST_START: begin
        w_tx_nxt = 1'b0;
        if (w_tick) begin
          w_state_nxt = ST_DATA;
          w_tx_nxt    = r_shift[0];
        end
      end

      ST_DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_idx == C_LAST_IDX) begin
            w_state_nxt = ST_PARITY;
            w_tx_nxt    = w_par_bit;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
            w_tx_nxt  = r_shift[1];
          end
        end
      end

      ST_PARITY: begin
        w_tx_nxt = w_par_bit;
        if (w_tick) begin
          w_state_nxt = ST_STOP;
          w_tx_nxt    = 1'b1;
        end
      end

      ST_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_tick) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule : parity_tx_framer
`default_nettype wire

// File: tb/tb_parity_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parity_tx_framer
//  Description : Self-checking bench for parity_tx_framer (CLKS_PER_BIT=4).
//                Expected line states are queued per cycle when a load is
//                driven and compared on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_tx_framer;

  localparam int CLKS_PER_BIT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       even_parity, odd_parity, parity_mode, load;
  logic       tx, busy, done, err;

  parity_tx_framer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .even_parity (even_parity),
    .odd_parity  (odd_parity),
    .parity_mode (parity_mode),
    .load        (load),
    .tx          (tx),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
    logic err;
  } obs_t;

  typedef struct {
    logic [7:0]  data;
    logic        ev;
    logic        od;
    logic        mode;
    logic        rej;
    logic [10:0] frame;  // bit i = line level in slot i
  } vec_t;

  obs_t sb_q[$];
  vec_t vecs[7];
  int   checks   = 0;
  int   failures = 0;

  localparam obs_t C_IDLE = '{tx: 1'b1, busy: 1'b0, done: 1'b0, err: 1'b0};
  localparam obs_t C_DONE = '{tx: 1'b1, busy: 1'b0, done: 1'b1, err: 1'b0};
  localparam obs_t C_ERR  = '{tx: 1'b1, busy: 1'b0, done: 1'b0, err: 1'b1};

  function automatic logic [10:0] frame_of(input logic [7:0] d, input logic p);
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic check_obs(input string name, input obs_t exp);
    obs_t act;
    act = '{tx: tx, busy: busy, done: done, err: err};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got tx/busy/done/err=%b required %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input string name);
    obs_t e;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty, got tx/busy/done/err=%b required none", name,
               {tx, busy, done, err});
    end else begin
      e = sb_q.pop_front();
      check_obs(name, e);
    end
  endtask

  task automatic push_frame(input logic [10:0] f);
    for (int s = 0; s < 11; s++)
      for (int c = 0; c < CLKS_PER_BIT; c++)
        sb_q.push_back('{tx: f[s], busy: 1'b1, done: 1'b0, err: 1'b0});
    sb_q.push_back(C_DONE);
  endtask

  task automatic drive(input logic [7:0] d, input logic ev, input logic od,
                       input logic m, input logic ld);
    data_in     = d;
    even_parity = ev;
    odd_parity  = od;
    parity_mode = m;
    load        = ld;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs[0] = '{data: 8'hA5, ev: 1'b1, od: 1'b0, mode: 1'b0, rej: 1'b0, frame: 11'h54A};
    vecs[1] = '{data: 8'hA5, ev: 1'b1, od: 1'b0, mode: 1'b1, rej: 1'b0, frame: 11'h74A};
    vecs[2] = '{data: 8'h07, ev: 1'b0, od: 1'b1, mode: 1'b0, rej: 1'b0, frame: 11'h60E};
    vecs[3] = '{data: 8'hA5, ev: 1'b1, od: 1'b1, mode: 1'b0, rej: 1'b1, frame: 11'h7FF};
    vecs[4] = '{data: 8'hA5, ev: 1'b0, od: 1'b0, mode: 1'b1, rej: 1'b1, frame: 11'h7FF};
    vecs[5] = '{data: 8'h00, ev: 1'b1, od: 1'b0, mode: 1'b1, rej: 1'b0, frame: 11'h600};
    vecs[6] = '{data: 8'hFF, ev: 1'b1, od: 1'b0, mode: 1'b0, rej: 1'b0, frame: 11'h5FE};

    rst_n = 1'b0;
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_obs("reset_state", C_IDLE);
    rst_n = 1'b1;
    sb_q.push_back(C_IDLE);
    step("idle_after_reset");

    // Table-driven single frames and rejected loads
    foreach (vecs[i]) begin
      drive(vecs[i].data, vecs[i].ev, vecs[i].od, vecs[i].mode, 1'b1);
      if (vecs[i].rej) begin
        sb_q.push_back(C_ERR);
        sb_q.push_back(C_IDLE);
      end else begin
        push_frame(vecs[i].frame);
      end
      sb_q.push_back(C_IDLE);
      step($sformatf("vec%0d", i));
      // Scramble inputs after the accepting edge; they must not matter.
      drive(~vecs[i].data, ~vecs[i].ev, vecs[i].ev, ~vecs[i].mode, 1'b0);
      while (sb_q.size() > 0) step($sformatf("vec%0d", i));
    end

    // Back-to-back with load held high the whole time
    drive(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    push_frame(frame_of(8'h3C, 1'b0));
    push_frame(frame_of(8'hC3, 1'b1));
    sb_q.push_back(C_IDLE);
    sb_q.push_back(C_IDLE);
    n = 0;
    while (sb_q.size() > 0) begin
      step("b2b");
      n++;
      if (n == 1)  drive(8'hC3, 1'b1, 1'b0, 1'b1, 1'b1);
      if (n == 47) load = 1'b0;
    end

    // Reset asserted during data slot 3 of 0xFF
    drive(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    push_frame(frame_of(8'hFF, 1'b0));
    step("rst_mid_pre");
    load = 1'b0;
    for (int j = 1; j <= 18; j++) step("rst_mid_pre");
    #2 rst_n = 1'b0;
    #1 check_obs("rst_mid_async", C_IDLE);
    sb_q.delete();
    repeat (3) sb_q.push_back(C_IDLE);
    while (sb_q.size() > 0) step("rst_mid_held");
    rst_n = 1'b1;
    repeat (2) sb_q.push_back(C_IDLE);
    while (sb_q.size() > 0) step("rst_mid_release");

    drive(8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
    push_frame(11'h7FE);
    sb_q.push_back(C_IDLE);
    step("after_reset_frame");
    load = 1'b0;
    while (sb_q.size() > 0) step("after_reset_frame");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_parity_tx_framer
`default_nettype wire
